// File: rtl/rc4_pkg.sv
// ============================================================================
// Module   : rc4_pkg
// Brief    : Shared RC4 PRGA types and constants (FAIL state exists only with
//            PRGA_CHAR_CHECK_EN defined).
// Revision : 1.0
// ============================================================================
`default_nettype none

package rc4_pkg;

  localparam int S_SIZE = 256;

  localparam logic [7:0] CHAR_LO    = 8'd97;
  localparam logic [7:0] CHAR_HI    = 8'd122;
  localparam logic [7:0] CHAR_SPACE = 8'd32;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    I_INC  = 4'd1,
    SI_RD  = 4'd2,
    SI_REG = 4'd3,
    J_UPD  = 4'd4,
    SJ_RD  = 4'd5,
    SJ_REG = 4'd6,
    SI_WR  = 4'd7,
    SJ_WR  = 4'd8,
    F_RD   = 4'd9,
    F_REG  = 4'd10,
    D_WR   = 4'd11,
    K_INC  = 4'd12,
    DONE   = 4'd13
`ifdef PRGA_CHAR_CHECK_EN
    ,
    FAIL   = 4'd14
`endif
  } prga_state_t;

endpackage

`default_nettype wire

// File: rtl/rc4_char_check.sv
// ============================================================================
// Module   : rc4_char_check
// Brief    : Flags a byte as valid plaintext: lowercase 'a'..'z' or space.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rc4_char_check
  import rc4_pkg::*;
(
  input  logic [7:0] data_in,
  output logic       valid
);

  assign valid = ((data_in >= CHAR_LO) && (data_in <= CHAR_HI)) ||
                 (data_in == CHAR_SPACE);

endmodule

`default_nettype wire

// File: rtl/rc4_prga.sv
// ============================================================================
// Module   : rc4_prga
// Brief    : RC4 PRGA keystream generator / decryptor, 12 cycles per byte.
//            Define PRGA_CHAR_CHECK_EN to abort on non-text output bytes.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rc4_prga
  import rc4_pkg::*;
#(
  parameter int MSG_LENGTH = 32
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start_sig,
  input  logic [7:0] q_s,
  output logic [7:0] addr_s,
  output logic [7:0] data_s,
  output logic       wren_s,
  input  logic [7:0] q_e,
  output logic [7:0] addr_e,
  output logic [7:0] addr_d,
  output logic [7:0] data_d,
  output logic       wren_d,
  output logic       finished_sig,
  output logic       bad_key_sig
);

  localparam int              IDX_W  = $clog2(S_SIZE);
  localparam logic [IDX_W-1:0] K_LAST = IDX_W'(MSG_LENGTH - 1);

  prga_state_t      r_state;
  prga_state_t      w_next;
  logic [IDX_W-1:0] r_i;
  logic [IDX_W-1:0] r_j;
  logic [IDX_W-1:0] r_k;
  logic [7:0]       r_si;
  logic [7:0]       r_sj;
  logic [7:0]       r_f;
  logic [7:0]       r_e;
  logic [7:0]       w_plain;

  assign w_plain = r_f ^ r_e;

`ifdef PRGA_CHAR_CHECK_EN
  logic w_char_ok;

  rc4_char_check u_char_check (
    .data_in (w_plain),
    .valid   (w_char_ok)
  );
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_i     <= '0;
      r_j     <= '0;
      r_k     <= '0;
      r_si    <= '0;
      r_sj    <= '0;
      r_f     <= '0;
      r_e     <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        I_INC:   r_i  <= r_i + 1'b1;
        SI_REG:  r_si <= q_s;
        J_UPD:   r_j  <= r_j + r_si;
        SJ_REG:  r_sj <= q_s;
        F_REG: begin
          r_f <= q_s;
          r_e <= q_e;
        end
        K_INC:   if (r_k != K_LAST) r_k <= r_k + 1'b1;
        default: ;
      endcase
    end
  end

  // Pre-swap si+sj equals post-swap S[i]+S[j], so F_RD can use the captured values.
  always_comb begin
    w_next = r_state;
    addr_s = '0;
    data_s = '0;
    wren_s = 1'b0;
    addr_e = '0;
    addr_d = '0;
    data_d = '0;
    wren_d = 1'b0;
    case (r_state)
      IDLE:   if (start_sig) w_next = I_INC;
      I_INC:  w_next = SI_RD;
      SI_RD: begin
        addr_s = r_i;
        w_next = SI_REG;
      end
      SI_REG: w_next = J_UPD;
      J_UPD:  w_next = SJ_RD;
      SJ_RD: begin
        addr_s = r_j;
        w_next = SJ_REG;
      end
      SJ_REG: w_next = SI_WR;
      SI_WR: begin
        addr_s = r_i;
        data_s = r_sj;
        wren_s = 1'b1;
        w_next = SJ_WR;
      end
      SJ_WR: begin
        addr_s = r_j;
        data_s = r_si;
        wren_s = 1'b1;
        w_next = F_RD;
      end
      F_RD: begin
        addr_s = r_si + r_sj;
        addr_e = r_k;
        w_next = F_REG;
      end
      F_REG:  w_next = D_WR;
      D_WR: begin
        addr_d = r_k;
        data_d = w_plain;
`ifdef PRGA_CHAR_CHECK_EN
        wren_d = w_char_ok;
        w_next = w_char_ok ? K_INC : FAIL;
`else
        wren_d = 1'b1;
        w_next = K_INC;
`endif
      end
      K_INC:  w_next = (r_k == K_LAST) ? DONE : I_INC;
      default: w_next = r_state;
    endcase
  end

`ifdef PRGA_CHAR_CHECK_EN
  assign finished_sig = (r_state == DONE) || (r_state == FAIL);
  assign bad_key_sig  = (r_state == FAIL);
`else
  assign finished_sig = (r_state == DONE);
  assign bad_key_sig  = 1'b0;
`endif

endmodule

`default_nettype wire
